// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: decodes frames into {ext, break, code} events in a FWFT FIFO; event visible 2 clk after the stop-bit strobe.
// Backpressure: key_ready pops the head; a push into a full FIFO without a same-cycle pop is dropped with overflow. Optional timeout: PS2_TIMEOUT_EN.
module ps2_key_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ps_clk,
  input  logic                           ps_data,
  output logic                           key_valid,
  input  logic                           key_ready,
  output logic [7:0]                     key_code,
  output logic                           key_break,
  output logic                           key_ext,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                           frame_err,
  output logic                           overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   edge_stb, bit_in;

  state_t     state, next_state;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic       frame_done, frame_good, tmo_hit;
  logic       ext_q, brk_q;
  logic       push_q;
  key_evt_t   push_dat;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  key_evt_t         mem [FIFO_DEPTH];
  key_evt_t         head;
  logic             full, pop, push_ok;

  // Synchronisers idle high so reset release never looks like a falling edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign edge_stb = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in   = data_sync[SYNC_STAGES-1];

`ifdef PS2_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tmo_cnt <= '0;
    else if (state == IDLE || edge_stb)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign tmo_hit = (state != IDLE) && !edge_stb && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      state    <= next_state;
      bit_cnt  <= bit_cnt_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
    end
  end

  always_comb begin
    next_state = state;
    bit_cnt_d  = bit_cnt;
    shift_d    = shift_q;
    parity_d   = parity_q;
    frame_done = 1'b0;
    frame_good = 1'b0;
    if (edge_stb) begin
      case (state)
        IDLE: begin
          if (!bit_in) begin
            next_state = DATA;
            bit_cnt_d  = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) next_state = PARITY;
        end
        PARITY: begin
          parity_d   = bit_in;
          next_state = STOP;
        end
        STOP: begin
          frame_done = 1'b1;
          frame_good = bit_in & (^{shift_q, parity_q});
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end else if (tmo_hit) begin
      next_state = IDLE;
    end
  end

  // Prefix bytes only set flags; any completed frame, good or bad, consumes them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      push_q    <= 1'b0;
      push_dat  <= '0;
    end else begin
      frame_err <= (frame_done & ~frame_good) | tmo_hit;
      push_q    <= 1'b0;
      if (frame_done && frame_good) begin
        if (shift_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          push_q   <= 1'b1;
          push_dat <= {ext_q, brk_q, shift_q};
          ext_q    <= 1'b0;
          brk_q    <= 1'b0;
        end
      end else if (frame_done || tmo_hit) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign pop     = key_valid & key_ready;
  assign push_ok = push_q & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_q & full & ~pop;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  assign head       = mem[rd_ptr];
  assign key_valid  = (count != '0);
  assign fifo_count = count;
  assign key_code   = key_valid ? head.code : 8'h00;
  assign key_break  = key_valid ? head.brk  : 1'b0;
  assign key_ext    = key_valid ? head.ext  : 1'b0;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver: bit-level PS/2 frames, FIFO fill/drain, errors, reset mid-frame.
module tb_ps2_key_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps_clk;
  logic       ps_data;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overflow;

  int tests = 0;
  int fails = 0;
  int ferr_hi = 0, ferr_rise = 0, ovf_hi = 0, ovf_rise = 0;
  logic ferr_d = 1'b0, ovf_d = 1'b0;
  logic [9:0] popped [$];
  int r0, h0, o0, oh0;

  always #5 clk = ~clk;

  ps2_key_receiver #(
    .SYNC_STAGES    (2),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps_clk     (ps_clk),
    .ps_data    (ps_data),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_code   (key_code),
    .key_break  (key_break),
    .key_ext    (key_ext),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  // Sampled late in the cycle, just before the next rising edge
  always begin
    @(negedge clk);
    #2;
    if (frame_err) ferr_hi++;
    if (frame_err && !ferr_d) ferr_rise++;
    ferr_d = frame_err;
    if (overflow) ovf_hi++;
    if (overflow && !ovf_d) ovf_rise++;
    ovf_d = overflow;
    if (key_valid && key_ready) popped.push_back({key_ext, key_break, key_code});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_fall(input logic b);
    ps_data = b;
    idle(4);
    ps_clk = 1'b0;
  endtask

  task automatic bit_rise();
    idle(8);
    ps_clk = 1'b1;
    idle(4);
  endtask

  task automatic send_bit(input logic b);
    bit_fall(b);
    bit_rise();
  endtask

  task automatic frame_head(input logic [7:0] code, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(par);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic stop);
    frame_head(code, (~^code) ^ bad_par);
    send_bit(stop);
    ps_data = 1'b1;
    idle(10);
  endtask

  task automatic good(input logic [7:0] code);
    send_frame(code, 1'b0, 1'b1);
  endtask

  task automatic pop_one();
    key_ready = 1'b1;
    idle(1);
    key_ready = 1'b0;
    idle(1);
  endtask

  // Pop lands on the same rising edge that writes the new entry
  task automatic frame_with_pop_at_push(input logic [7:0] code);
    frame_head(code, ~^code);
    bit_fall(1'b1);
    idle(3);
    key_ready = 1'b1;
    idle(1);
    key_ready = 1'b0;
    bit_rise();
    ps_data = 1'b1;
    idle(10);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, key_valid, 0);
    check({tag, "_code"}, key_code, 0);
    check({tag, "_break"}, key_break, 0);
    check({tag, "_ext"}, key_ext, 0);
    check({tag, "_count"}, fifo_count, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    ps_clk = 1'b1;
    ps_data = 1'b1;
    key_ready = 1'b0;
    reset = 1'b1;
    idle(3);
    check_zero("rst_held");
    reset = 1'b0;
    idle(5);
    check_zero("rst_rel");
    check("rst_no_ferr", ferr_rise, 0);

    // 0x1C, parity 0: key_valid rises four cycles after the stop-bit fall
    frame_head(8'h1C, 1'b0);
    bit_fall(1'b1);
    idle(3);
    check("lat_valid_early", key_valid, 0);
    check("lat_ferr_good", frame_err, 0);
    idle(1);
    check("lat_valid", key_valid, 1);
    check("lat_code", key_code, 8'h1C);
    check("lat_break", key_break, 0);
    check("lat_ext", key_ext, 0);
    check("lat_count", fifo_count, 1);
    bit_rise();
    ps_data = 1'b1;
    idle(10);
    pop_one();
    check("pop1_n", popped.size(), 1);
    check("pop1_dat", popped[0], 10'h01C);
    check("pop1_empty_valid", key_valid, 0);
    check("pop1_empty_code", key_code, 0);
    check("pop1_no_ferr", ferr_rise, 0);

    // E0 F0 75 then plain 75
    popped.delete();
    good(8'hE0);
    good(8'hF0);
    check("pfx_no_push", fifo_count, 0);
    good(8'h75);
    check("ef_count", fifo_count, 1);
    check("ef_code", key_code, 8'h75);
    check("ef_ext", key_ext, 1);
    check("ef_break", key_break, 1);
    good(8'h75);
    check("ef2_count", fifo_count, 2);
    pop_one();
    check("plain_code", key_code, 8'h75);
    check("plain_ext", key_ext, 0);
    check("plain_break", key_break, 0);
    pop_one();
    check("ef_pop0", popped[0], 10'h375);
    check("ef_pop1", popped[1], 10'h075);
    check("ef_empty", fifo_count, 0);

    // Bad parity, bad stop, flag clearing on error
    r0 = ferr_rise;
    h0 = ferr_hi;
    send_frame(8'h23, 1'b1, 1'b1);
    check("par_ferr_pulse", ferr_rise, r0 + 1);
    check("par_ferr_width", ferr_hi, h0 + 1);
    check("par_count", fifo_count, 0);
    good(8'h23);
    check("par_recover_count", fifo_count, 1);
    check("par_recover_code", key_code, 8'h23);
    pop_one();
    send_frame(8'h15, 1'b0, 1'b0);
    check("stop_ferr_pulse", ferr_rise, r0 + 2);
    check("stop_count", fifo_count, 0);
    good(8'hF0);
    send_frame(8'h23, 1'b1, 1'b1);
    good(8'h2B);
    check("errclr_code", key_code, 8'h2B);
    check("errclr_break", key_break, 0);
    check("errclr_ferr", ferr_rise, r0 + 3);
    pop_one();

    // Overflow with depth 4
    o0 = ovf_rise;
    oh0 = ovf_hi;
    good(8'h16); good(8'h1E); good(8'h26);
    good(8'h25); good(8'h2E); good(8'h36);
    check("ovf_count", fifo_count, 4);
    check("ovf_pulses", ovf_rise, o0 + 2);
    check("ovf_width", ovf_hi, oh0 + 2);
    check("ovf_head", key_code, 8'h16);
    frame_with_pop_at_push(8'h3D);
    check("fullpp_count", fifo_count, 4);
    check("fullpp_no_ovf", ovf_rise, o0 + 2);
    check("fullpp_head", key_code, 8'h1E);
    popped.delete();
    repeat (4) pop_one();
    check("drain_0", popped[0], 10'h01E);
    check("drain_1", popped[1], 10'h026);
    check("drain_2", popped[2], 10'h025);
    check("drain_3", popped[3], 10'h03D);
    check("drain_count", fifo_count, 0);
    good(8'h44);
    frame_with_pop_at_push(8'h4B);
    check("pp_count", fifo_count, 1);
    check("pp_head", key_code, 8'h4B);
    pop_one();

    // Reset during bit 5 with two entries queued and ext pending
    good(8'h1C);
    good(8'h32);
    check("mid_pre_count", fifo_count, 2);
    good(8'hE0);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(r0[i] ^ 1'b1);
    bit_fall(1'b0);
    idle(2);
    r0 = ferr_rise;
    reset = 1'b1;
    idle(2);
    ps_clk = 1'b1;
    ps_data = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(5);
    check_zero("mid_rst");
    check("mid_no_ferr", ferr_rise, r0);
    good(8'h5A);
    check("mid_next_count", fifo_count, 1);
    check("mid_next_code", key_code, 8'h5A);
    check("mid_next_ext", key_ext, 0);
    check("mid_next_break", key_break, 0);
    pop_one();

`ifdef PS2_TIMEOUT_EN
    // Clock stops after start bit plus three data bits
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    r0 = ferr_rise;
    idle(80);
    check("tmo_not_yet", ferr_rise, r0);
    idle(20);
    check("tmo_ferr", ferr_rise, r0 + 1);
    good(8'h1C);
    check("tmo_next_count", fifo_count, 1);
    check("tmo_next_code", key_code, 8'h1C);
    pop_one();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops in the synchroniser for each of ps_clk and ps_data; minimum 2.
REQ-002 Parameter FIFO_DEPTH, default 8: number of key-event entries in the FIFO; power of two, minimum 2.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000: idle clk cycles inside a frame before the frame is aborted (about 1 ms at 50 MHz).
REQ-004 Port clk, input, 1 bit: 50 MHz system clock, the only clock.
REQ-005 Port reset, input, 1 bit: asynchronous reset, active-high.
REQ-006 Port ps_clk, input, 1 bit: PS/2 clock from the keyboard, asynchronous to clk.
REQ-007 Port ps_data, input, 1 bit: PS/2 data from the keyboard, asynchronous to clk.
REQ-008 Port key_valid, output, 1 bit: the FIFO head holds a key event.
REQ-009 Port key_ready, input, 1 bit: the consumer accepts the head entry.
REQ-010 Port key_code, output, 8 bits: scan code of the head entry.
REQ-011 Port key_break, output, 1 bit: the head entry is a release (F0-prefixed).
REQ-012 Port key_ext, output, 1 bit: the head entry is extended (E0-prefixed).
REQ-013 Port fifo_count, output, clog2(FIFO_DEPTH+1) bits: number of occupied FIFO entries.
REQ-014 Port frame_err, output, 1 bit: one-cycle pulse on a bad or aborted frame.
REQ-015 Port overflow, output, 1 bit: one-cycle pulse when a key event is dropped.

Function
REQ-016 ps_clk and ps_data SHALL each pass through SYNC_STAGES flops; a falling-edge strobe SHALL be derived from the synchronised ps_clk.
REQ-017 The FSM SHALL have the states IDLE, DATA, PARITY and STOP; all samples SHALL be taken on the edge strobe only.
REQ-018 In IDLE, a sampled data value of 0 SHALL move the FSM to DATA with the bit counter at 0; a sampled 1 SHALL leave the FSM in IDLE (no start bit).
REQ-019 DATA SHALL shift in 8 bits LSB first, then go to PARITY; PARITY SHALL capture one bit and go to STOP; STOP SHALL capture one bit and return to IDLE.
REQ-020 A frame SHALL be good only when the stop bit is 1 and the 8 data bits plus the parity bit have odd parity; otherwise frame_err SHALL pulse in cycle N+1, where N is the stop-edge cycle.
REQ-021 A good frame with code 0xE0 SHALL set the ext flag, and a good frame with code 0xF0 SHALL set the break flag; neither SHALL push an entry.
REQ-022 Any other good frame SHALL push {ext, break, code} at the end of cycle N+1 and then clear both flags; key_valid SHALL be high in cycle N+2 if the FIFO was empty.
REQ-023 A frame error SHALL clear both flags.
REQ-024 The FIFO SHALL be first-word fall-through: key_code, key_break and key_ext show the head entry whenever key_valid is 1.
REQ-025 key_valid SHALL be 1 exactly when fifo_count is nonzero.
REQ-026 A pop SHALL occur in any cycle where key_valid and key_ready are both 1.
REQ-027 A push while full with no pop in the same cycle SHALL drop the new event, pulse overflow for one cycle, and leave the FIFO unchanged.
REQ-028 A push while full with a pop in the same cycle SHALL succeed, and fifo_count SHALL stay at FIFO_DEPTH.
REQ-029 A simultaneous push and pop at any other fill level SHALL leave fifo_count unchanged.
REQ-030 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 When the FIFO is empty, key_code, key_break and key_ext SHALL be 0.

Reset
REQ-032 While reset is 1, all state SHALL clear asynchronously: FSM to IDLE, bit counter 0, flags 0, FIFO pointers and count 0.
REQ-033 Synchroniser flops SHALL reset to 1 (bus idle) so that no edge strobe follows reset release.
REQ-034 Reset values of outputs: key_valid 0, key_code 0x00, key_break 0, key_ext 0, fifo_count 0, frame_err 0, overflow 0.
REQ-035 Reset asserted mid-frame SHALL discard the partial frame and all FIFO contents, and SHALL produce no frame_err pulse.

Configuration
REQ-036 With PS2_TIMEOUT_EN defined, a cycle counter SHALL run while the FSM is not in IDLE and reload on each edge strobe.
REQ-037 With PS2_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL return the FSM to IDLE, clear both flags, and pulse frame_err.
REQ-038 Without PS2_TIMEOUT_EN, the FSM SHALL wait indefinitely in a frame, TIMEOUT_CYCLES SHALL be ignored, and no timeout logic SHALL be synthesised.

Verification
REQ-039 Frame 0x1C with parity 0 and stop 1, key_ready=1 -> one pop with key_code=0x1C, break=0, ext=0, and no frame_err.
REQ-040 Frames E0, F0, 75 -> a single entry with key_code=0x75, ext=1, break=1; a following frame 0x75 -> an entry with ext=0, break=0.
REQ-041 Frame 0x23 with parity 1 (wrong) -> frame_err pulses for one cycle, fifo_count stays 0, and a subsequent good frame is accepted.
REQ-042 FIFO_DEPTH=4, key_ready=0, six good frames -> fifo_count=4, two overflow pulses, and the head is still the first code.
REQ-043 PS2_TIMEOUT_EN defined with TIMEOUT_CYCLES=100, ps_clk stopped after 4 bits -> frame_err pulses after 100 cycles and the next full frame is decoded correctly.
REQ-044 Reset pulsed during bit 5 of a frame while 2 entries are queued -> all outputs read 0 and the next complete frame is decoded cleanly.
